regfile_wb_queue: RTL

// Write-side companion of the register file: collects writeback results from execute units,

---
 rtl/regfile_wb_queue.sv | 98 +++++++++
 1 files changed

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue in front of the regfile write port, with two bypass lookup ports
// that expose results still waiting in the queue.
module regfile_wb_queue #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned QDEPTH = 4,
   localparam int unsigned ADDR  = $clog2(DEPTH),
   localparam int unsigned CNTW  = $clog2(QDEPTH + 1),
   localparam int unsigned PTRW  = $clog2(QDEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ADDR-1:0]  in_reg,
   input  logic [WIDTH-1:0] in_data,
   input  logic             wb_stall,
   output logic             enable,
   output logic [ADDR-1:0]  wreg,
   output logic [WIDTH-1:0] wdata,
   input  logic [ADDR-1:0]  rreg1,
   output logic             byp_hit1,
   output logic [WIDTH-1:0] byp_data1,
   input  logic [ADDR-1:0]  rreg2,
   output logic             byp_hit2,
   output logic [WIDTH-1:0] byp_data2,
   output logic [CNTW-1:0]  count
);

   logic [ADDR-1:0]  reg_q  [QDEPTH];
   logic [WIDTH-1:0] data_q [QDEPTH];
   logic [PTRW-1:0]  head_q, tail_q;
   logic [CNTW-1:0]  count_q, count_d;
   logic             push, pop;
   logic [PTRW-1:0]  idx;

   // Reset gates the write port so nothing reaches the regfile in the reset cycle.
   assign enable   = (count_q != '0) && !wb_stall && !reset;
   assign pop      = enable;
   assign in_ready = (count_q < CNTW'(QDEPTH)) || enable;
   // Writes to register 0 complete the handshake but are dropped.
   assign push     = in_valid && in_ready && (in_reg != '0);
   assign wreg     = reg_q[head_q];
   assign wdata    = data_q[head_q];
   assign count    = count_q;

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + PTRW'(1);
         if (pop)  head_q <= head_q + PTRW'(1);
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible below count_q.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         reg_q[tail_q]  <= in_reg;
         data_q[tail_q] <= in_data;
      end
   end

   // Scan oldest to youngest so the last match (youngest) wins.
   always_comb begin
      byp_hit1  = 1'b0;
      byp_data1 = '0;
      byp_hit2  = 1'b0;
      byp_data2 = '0;
      idx       = '0;
      for (int i = 0; i < QDEPTH; i++) begin
         idx = head_q + PTRW'(i);
         if (CNTW'(i) < count_q) begin
            if ((rreg1 != '0) && (reg_q[idx] == rreg1)) begin
               byp_hit1  = 1'b1;
               byp_data1 = data_q[idx];
            end
            if ((rreg2 != '0) && (reg_q[idx] == rreg2)) begin
               byp_hit2  = 1'b1;
               byp_data2 = data_q[idx];
            end
         end
      end
   end

endmodule
